// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Conditions the board push-buttons for the scene logic. Each channel has a
// 2-flop synchronizer, a counter-based debouncer and registered one-cycle
// press/release pulses. All logic runs on the pixel clock.
//
// Optional feature (compile-time macro BTN_AUTOREPEAT_EN):
//   When defined, a held button produces auto-repeat press pulses, the first
//   REPEAT_DELAY cycles after the accepted press and then every
//   REPEAT_PERIOD cycles until the release is accepted. When undefined, no
//   repeat logic exists and the REPEAT_* parameters have no effect.
//
// Parameters:
//   N_BTN           number of independent button channels
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a level (>= 2)
//   REPEAT_DELAY    cycles from accepted press to first auto-repeat pulse
//   REPEAT_PERIOD   cycles between subsequent auto-repeat pulses
//
// Ports:
//   clk         in   1      pixel clock, all logic on posedge
//   rst         in   1      synchronous active-high reset
//   btn_in      in   N_BTN  raw asynchronous button pins
//   btn_level   out  N_BTN  debounced level
//   btn_press   out  N_BTN  one-cycle pulse on accepted 0->1 (and repeats)
//   btn_release out  N_BTN  one-cycle pulse on accepted 1->0
//   any_press   out  1      OR of btn_press, aligned with btn_press
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time sanity checks on the configuration.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    logic             r_any;
    logic [CNT_W-1:0] r_cnt [N_BTN];

    logic [N_BTN-1:0] w_accept;
    logic [N_BTN-1:0] w_press_next;
    logic [N_BTN-1:0] w_release_next;
    logic [N_BTN-1:0] w_rpt_pulse;

    // A level is accepted when the synchronized input has disagreed with the
    // current level for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        w_accept       = '0;
        w_press_next   = '0;
        w_release_next = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_accept[i]       = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
            w_press_next[i]   = (w_accept[i] && r_sync2[i]) || w_rpt_pulse[i];
            w_release_next[i] = w_accept[i] && !r_sync2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
            r_any     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= btn_in;
            r_sync2   <= r_sync1;
            r_level   <= r_level ^ w_accept;
            r_press   <= w_press_next;
            r_release <= w_release_next;
            r_any     <= |w_press_next;
            for (int i = 0; i < N_BTN; i++) begin
                if (r_sync2[i] == r_level[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W  = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RCNT_W-1:0] RD_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RP_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_WAIT_DELAY,
        RPT_REPEATING
    } rpt_state_t;

    rpt_state_t        r_rstate      [N_BTN];
    rpt_state_t        w_rstate_next [N_BTN];
    logic [RCNT_W-1:0] r_rcnt        [N_BTN];
    logic [RCNT_W-1:0] w_rcnt_next   [N_BTN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                r_rstate[i] <= RPT_IDLE;
                r_rcnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                r_rstate[i] <= w_rstate_next[i];
                r_rcnt[i]   <= w_rcnt_next[i];
            end
        end
    end

    // Outside IDLE the level is 1, so any accept there is a release; it wins
    // over a repeat pulse falling on the same edge.
    always_comb begin
        w_rpt_pulse = '0;
        for (int i = 0; i < N_BTN; i++) begin
            w_rstate_next[i] = r_rstate[i];
            w_rcnt_next[i]   = r_rcnt[i];
            case (r_rstate[i])
                RPT_IDLE: begin
                    if (w_accept[i] && r_sync2[i]) begin
                        w_rstate_next[i] = RPT_WAIT_DELAY;
                        w_rcnt_next[i]   = '0;
                    end
                end
                RPT_WAIT_DELAY: begin
                    if (w_accept[i]) begin
                        w_rstate_next[i] = RPT_IDLE;
                        w_rcnt_next[i]   = '0;
                    end else if (r_rcnt[i] == RD_LAST) begin
                        w_rpt_pulse[i]   = 1'b1;
                        w_rstate_next[i] = RPT_REPEATING;
                        w_rcnt_next[i]   = '0;
                    end else begin
                        w_rcnt_next[i]   = r_rcnt[i] + 1'b1;
                    end
                end
                RPT_REPEATING: begin
                    if (w_accept[i]) begin
                        w_rstate_next[i] = RPT_IDLE;
                        w_rcnt_next[i]   = '0;
                    end else if (r_rcnt[i] == RP_LAST) begin
                        w_rpt_pulse[i]   = 1'b1;
                        w_rcnt_next[i]   = '0;
                    end else begin
                        w_rcnt_next[i]   = r_rcnt[i] + 1'b1;
                    end
                end
                default: begin
                    w_rstate_next[i] = RPT_IDLE;
                    w_rcnt_next[i]   = '0;
                end
            endcase
        end
    end
`else
    assign w_rpt_pulse = '0;
`endif

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign any_press   = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//
// Drives directed and randomized button activity. The reference model keeps
// the full per-edge history of what the synchronizer captured and accepts a
// new level whenever a sliding window of DEBOUNCE_CYCLES captured samples
// (delayed two edges by the synchronizer) all disagree with the current
// level and no reset fell inside that window. Expected outputs are queued
// per edge; a separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int N    = 5;
    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RP   = 3;
    localparam int MAXE = 4096;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic         any_press;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] rel;
        logic         any;
    } exp_t;

    exp_t         sb_q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc_no = 0;

    logic [N-1:0] hist [MAXE];
    bit           rsth [MAXE];
    logic [N-1:0] m_lvl;
    int           acc_e [N];
    int           e = 0;

    // Reference model for one rising edge given the inputs seen at that edge.
    function automatic void model_edge(input logic r, input logic [N-1:0] din);
        exp_t         x;
        logic [N-1:0] p;
        logic [N-1:0] rl;
        bit           ok;
        p  = '0;
        rl = '0;
        hist[e] = r ? '0 : din;
        rsth[e] = r;
        if (r) begin
            m_lvl = '0;
            for (int i = 0; i < N; i++) acc_e[i] = -1000000;
        end else begin
            for (int i = 0; i < N; i++) begin
                ok = 1'b1;
                for (int u = e - D + 1; u <= e; u++) begin
                    if (u < 2) ok = 1'b0;
                    else if (rsth[u] || hist[u-2][i] == m_lvl[i]) ok = 1'b0;
                end
                if (ok) begin
                    if (m_lvl[i] == 1'b0) p[i] = 1'b1;
                    else rl[i] = 1'b1;
                    m_lvl[i] = ~m_lvl[i];
                    acc_e[i] = e;
                end else if (AR && m_lvl[i] && (e - acc_e[i]) >= RD &&
                             ((e - acc_e[i] - RD) % RP) == 0) begin
                    p[i] = 1'b1;
                end
            end
        end
        x.lvl = m_lvl;
        x.prs = p;
        x.rel = rl;
        x.any = |p;
        sb_q.push_back(x);
        e++;
    endfunction

    task automatic hold(input int n, input logic r, input logic [N-1:0] b);
        for (int k = 0; k < n; k++) begin
            rst    = r;
            btn_in = b;
            @(posedge clk);
            model_edge(r, b);
            #1;
        end
    endtask

    // Monitor: one queued expectation per rising edge, checked mid-cycle.
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            tests++;
            if (btn_level !== x.lvl || btn_press !== x.prs ||
                btn_release !== x.rel || any_press !== x.any) begin
                fails++;
                $display("FAIL edge%0d outputs: got lvl=%h prs=%h rel=%h any=%b, expected lvl=%h prs=%h rel=%h any=%b",
                         cyc_no, btn_level, btn_press, btn_release, any_press,
                         x.lvl, x.prs, x.rel, x.any);
            end
            cyc_no++;
        end
    end

    initial begin
        logic [N-1:0] b;
        rst    = 1'b1;
        btn_in = '0;
        m_lvl  = '0;
        for (int i = 0; i < N; i++) acc_e[i] = -1000000;

        // Reset with all buttons held, then release reset.
        hold(3, 1'b1, 5'h1F);
        hold(12, 1'b0, 5'h1F);
        hold(10, 1'b0, 5'h00);

        // Clean press on bit 0.
        hold(10, 1'b0, 5'h01);

        // Bounce on bit 2, then settle high.
        hold(2, 1'b0, 5'h05);
        hold(2, 1'b0, 5'h01);
        hold(2, 1'b0, 5'h05);
        hold(2, 1'b0, 5'h01);
        hold(10, 1'b0, 5'h05);

        // Simultaneous: bit 3 high first, then bit 1 rises as bit 3 falls.
        hold(10, 1'b0, 5'h0D);
        hold(10, 1'b0, 5'h07);

        // Reset in the middle of a count on bit 4.
        hold(2, 1'b0, 5'h17);
        hold(1, 1'b1, 5'h17);
        hold(12, 1'b0, 5'h17);

        // Long hold on bit 0 (auto-repeat window), then release.
        hold(10, 1'b0, 5'h00);
        hold(40, 1'b0, 5'h01);
        hold(15, 1'b0, 5'h00);

        // Random per-bit flips with occasional reset.
        b = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
            hold(1, ($urandom_range(0, 99) == 0), b);
        end

        // Random levels held for random stretches.
        for (int s = 0; s < 30; s++) begin
            b = N'($urandom_range(0, 31));
            hold($urandom_range(1, 20), 1'b0, b);
        end
        hold(12, 1'b0, 5'h00);

        @(negedge clk);
        #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the five board push-buttons for the scene logic: per-button 2-flop synchronizer, counter-based debounce, and one-cycle press/release pulses.
- Sits between the board button pins and main_scene, in the pixel-clock domain.
- Replaces the bare 3-flop shift synchronizers, so the scene logic receives clean levels and single-cycle edge events.

Parameters:
- N_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a new level (10 ms at 25 MHz pixel clock). Must be >= 2.
- REPEAT_DELAY, 12500000, cycles from accepted press to first auto-repeat pulse (500 ms). Used only with the optional feature.
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeat pulses (100 ms). Used only with the optional feature.

Ports:
- clk  input  1  pixel clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw asynchronous button pins, bit i = button i.
- btn_level  output  N_BTN  debounced button level.
- btn_press  output  N_BTN  one-cycle pulse on an accepted 0->1 transition (and on auto-repeat).
- btn_release  output  N_BTN  one-cycle pulse on an accepted 1->0 transition.
- any_press  output  1  registered OR of the btn_press inputs, aligned with btn_press.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state clears only on a clk edge with rst=1.
- Reset values: btn_level=0, btn_press=0, btn_release=0, any_press=0, synchronizers=0, counters=0. No async paths.
- Synchronizer: per button, s1<=btn_in[i], s2<=s1. Only s2 feeds the debouncer.
- Debounce counter: per button, width $clog2(DEBOUNCE_CYCLES). At each edge:
  - If s2==btn_level[i]: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: btn_level[i]<=s2, cnt<=0, and pulse on the matching output (press if s2=1, release if s2=0).
  - Else: cnt<=cnt+1.
- Latency: a clean step on btn_in first sampled at edge k updates btn_level and its pulse at edge k+1+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges inclusive.
- Glitches: any return of s2 to btn_level before the count completes resets cnt to 0. Bounces shorter than DEBOUNCE_CYCLES never produce a pulse.
- Pulses: btn_press and btn_release are high for exactly one cycle and are zero on all other cycles. Press and release on the same bit never occur in the same cycle.
- Channels are fully independent. Simultaneous events on several bits pulse in the same cycle. any_press goes high that cycle.
- Reset mid-operation: partial counts are discarded. A button held through reset deassertion is treated as a new press: btn_press fires DEBOUNCE_CYCLES+2 edges after the first non-reset edge.
- No state machine beyond the per-channel {IDLE_LOW, COUNTING, IDLE_HIGH} implied by level/cnt. Auto-repeat adds per-channel {WAIT_DELAY, REPEATING} (see Optional Feature).

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- When defined:
  - Each channel has a repeat counter, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)).
  - On an accepted press, the channel enters WAIT_DELAY with rcnt=0.
  - While btn_level[i]=1, rcnt increments. At rcnt==REPEAT_DELAY-1: btn_press pulses, rcnt<=0, state -> REPEATING.
  - In REPEATING, a pulse fires every REPEAT_PERIOD cycles.
  - An accepted release or rst clears rcnt and returns to idle immediately. No repeat pulse is issued in the release cycle.
  - any_press also reflects repeat pulses.
- When undefined: no repeat logic is synthesized, REPEAT_* parameters are ignored, and btn_press fires once per accepted press.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset: hold rst 3 cycles with btn_in=5'h1F -> all outputs 0 during reset. After release, btn_level=5'h1F and btn_press=5'h1F for one cycle, 6 edges after the first non-reset edge.
- Clean press: btn_in[0] 0->1 sampled at edge 10 -> btn_level[0]=1 and btn_press[0]=1 after edge 15 only. any_press=1 that same cycle.
- Bounce: btn_in[2] toggles 1,0,1,0 every 2 cycles, then holds 1 -> exactly one btn_press[2], 6 edges after the final rising edge. No btn_release[2].
- Simultaneous: btn_in[1] rises while btn_in[3] falls (btn_level[3]=1) on the same edge -> btn_press[1] and btn_release[3] pulse in the same cycle. Other bits stay 0.
- Reset mid-count: btn_in[4] rises, rst asserted 2 edges later for 1 cycle -> no pulse until 6 edges after rst deasserts, then btn_press[4]=1 once.
- BTN_AUTOREPEAT_EN: hold btn_in[0] high for 40 cycles -> press at the accept cycle, repeat pulses at +10, +13, +16, ...; release -> btn_release[0] pulses and repeats stop. Without the macro -> exactly one press pulse.
